// File: rtl/bc_fir_pkg.sv
// Shared types, default coefficient set and width helpers for the folded
// symmetric FIR (bc_fir_seq).
package bc_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_H = 10;

    // Folded 19-tap set; entries above 2047 are negative taps in 12-bit wrap.
    localparam logic [11:0] DEFAULT_COEF [DEFAULT_H] = '{
        12'd3, 12'd0, 12'd4075, 12'd0, 12'd78,
        12'd0, 12'd3859, 12'd0, 12'd943, 12'd1533
    };

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    function automatic logic [11:0] default_coef(input int i);
        if (i >= 0 && i < DEFAULT_H)
            return DEFAULT_COEF[i];
        return 12'd0;
    endfunction

endpackage

// File: rtl/bc_fir_mac.sv
// Pre-adder, multiplier and accumulator for one folded coefficient pair per
// cycle. Exposes the output slice of the sum being formed this cycle.
module bc_fir_mac #(
    parameter int DATA_W = 13,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 31,
    parameter int SHIFT  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [COEF_W-1:0] coef,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);
    localparam int PW = DATA_W + COEF_W + 1;

    logic [DATA_W:0]    pre;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;

    assign pre      = {1'b0, a} + {1'b0, b};
    assign prod     = PW'(pre) * PW'(coef);
    assign acc_next = acc + ACC_W'(prod);
    assign result   = acc_next[SHIFT +: DATA_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/bc_fir_seq.sv
// Streaming symmetric FIR: one sample per handshake, folded taps evaluated on
// a single time-shared multiplier, run-time writable coefficient file.
module bc_fir_seq
    import bc_fir_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int COEF_W = 12,
    parameter int TAPS   = 19,
    parameter int SHIFT  = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    input  logic                             coef_we,
    input  logic [$clog2((TAPS+1)/2)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]                coef_data
);
    localparam int H     = (TAPS + 1) / 2;
    localparam int IW    = $clog2(H);
    localparam int TW    = $clog2(TAPS);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] d [TAPS];
    logic [COEF_W-1:0] c [H];
    logic [TW-1:0]     mirror;
    logic              last;
    logic [DATA_W-1:0] tap_a;
    logic [DATA_W-1:0] tap_b;
    logic [DATA_W-1:0] result;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    assign in_ready = (state == ST_IDLE);
    assign last     = (idx == IW'(H - 1));
    assign mirror   = TW'(TAPS - 1) - TW'(idx);
    assign tap_a    = d[TW'(idx)];
    assign tap_b    = last ? '0 : d[mirror];

    bc_fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clr    (in_valid && in_ready),
        .en     (state == ST_MAC),
        .coef   (c[idx]),
        .a      (tap_a),
        .b      (tap_b),
        .result (result)
    );

    // A write coinciding with an accept lands before the first MAC cycle reads it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < H; i++)
                c[i] <= COEF_W'(default_coef(i));
        end else if (coef_we && in_ready && (int'(coef_addr) < H)) begin
            c[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < TAPS; k++)
                d[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int k = TAPS - 1; k > 0; k--)
                            d[k] <= d[k-1];
                        d[0]  <= in_data;
                        idx   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bc_fir_seq.sv
// Directed self-checking bench for bc_fir_seq with default parameters.
module tb_bc_fir_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [11:0] coef_data;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    logic [12:0] imp_exp [19];
    logic [12:0] got [40];
    int          lat [40];
    int          acc_at [40];

    always #5 clock = ~clock;

    bc_fir_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
        cnt++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [11:0] v);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = v;
        step();
        coef_we = 1'b0;
    endtask

    task automatic accept(input logic [12:0] x, output int at);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait in_ready=%0b required=1", in_ready);
        end
        step();
        at = cnt;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [12:0] y, output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_wait out_valid=%0b required=1", out_valid);
        end
        y = out_data;
    endtask

    task automatic stream(input int n, input logic [12:0] first, input logic [12:0] rest);
        for (int i = 0; i < n; i++) begin
            accept((i == 0) ? first : rest, acc_at[i]);
            wait_out(got[i], lat[i]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 13'd0) begin
            errors++;
            $display("FAIL reset_out_data got=%0d exp=0", out_data);
        end
    endtask

    task automatic test_impulse();
        do_reset();
        stream(19, 13'd1, 13'd0);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (got[i] !== imp_exp[i]) begin
                errors++;
                $display("FAIL impulse[%0d] got=%0d exp=%0d", i, got[i], imp_exp[i]);
            end
        end
        checks++;
        if (lat[0] !== 11) begin
            errors++;
            $display("FAIL impulse_latency got=%0d exp=11", lat[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 19; i++) begin
            checks++;
            if (acc_at[i] - acc_at[i-1] !== 12) begin
                errors++;
                $display("FAIL throughput[%0d] got=%0d exp=12", i, acc_at[i] - acc_at[i-1]);
            end
        end
    endtask

    task automatic test_dc();
        do_reset();
        stream(40, 13'd1, 13'd1);
        for (int i = 18; i < 40; i++) begin
            checks++;
            if (got[i] !== 13'd3065) begin
                errors++;
                $display("FAIL dc[%0d] got=%0d exp=3065", i, got[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] y;
        int          c;
        int          at;
        int          rise;
        do_reset();
        out_ready = 1'b0;
        accept(13'd1, at);
        wait_out(y, c);
        checks++;
        if (y !== 13'd3) begin
            errors++;
            $display("FAIL bp_first got=%0d exp=3", y);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 13'd3) begin
                errors++;
                $display("FAIL bp_hold[%0d] out_valid=%0b in_ready=%0b out_data=%0d exp 1/0/3",
                         i, out_valid, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        rise = cnt;
        accept(13'd0, at);
        checks++;
        if (at - rise !== 2) begin
            errors++;
            $display("FAIL bp_accept_delay got=%0d exp=2", at - rise);
        end
        wait_out(y, c);
        checks++;
        if (y !== 13'd0) begin
            errors++;
            $display("FAIL bp_second got=%0d exp=0", y);
        end
    endtask

    task automatic test_coef_load();
        logic [12:0] e;
        do_reset();
        write_coef(4'd9, 12'd100);
        write_coef(4'd12, 12'd777);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 12'd7;
        accept(13'd1, acc_at[0]);
        coef_data = 12'd55;
        step();
        coef_we = 1'b0;
        wait_out(got[0], lat[0]);
        for (int i = 1; i < 19; i++) begin
            accept(13'd0, acc_at[i]);
            wait_out(got[i], lat[i]);
        end
        for (int i = 0; i < 19; i++) begin
            e = imp_exp[i];
            if (i == 0 || i == 18) e = 13'd7;
            if (i == 9) e = 13'd100;
            checks++;
            if (got[i] !== e) begin
                errors++;
                $display("FAIL coef_load[%0d] got=%0d exp=%0d", i, got[i], e);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int at;
        int seen = 0;
        accept(13'd1, at);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midmac_reset out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midmac_no_valid got=%0d exp=0", seen);
        end
        stream(19, 13'd1, 13'd0);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (got[i] !== imp_exp[i]) begin
                errors++;
                $display("FAIL midmac_impulse[%0d] got=%0d exp=%0d", i, got[i], imp_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 9; i++)
            write_coef(4'(i), 12'd0);
        write_coef(4'd9, 12'd4095);
        stream(19, 13'd8191, 13'd8191);
        for (int i = 0; i < 19; i++) begin
            e = (i >= 9) ? 13'd4097 : 13'd0;
            checks++;
            if (got[i] !== e) begin
                errors++;
                $display("FAIL wrap[%0d] got=%0d exp=%0d", i, got[i], e);
            end
        end
    endtask

    initial begin
        imp_exp = '{13'd3, 13'd0, 13'd4075, 13'd0, 13'd78, 13'd0, 13'd3859, 13'd0, 13'd943,
                    13'd1533, 13'd943, 13'd0, 13'd3859, 13'd0, 13'd78, 13'd0, 13'd4075,
                    13'd0, 13'd3};
        test_reset();
        test_impulse();
        test_back_to_back();
        test_dc();
        test_backpressure();
        test_coef_load();
        test_reset_mid_mac();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
